// File: rtl/mem_master.sv
// Data-memory initiator: accepts one word access at a time, drives the DM
// strobes, samples read data after a fixed wait and holds the response.
module mem_master #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_WORDS  = 65
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_fetch,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        R_Enable,
  output logic        W_Enable,
  output logic        IorD,
  output logic [31:0] Addr,
  output logic [31:0] W_data,
  input  logic [31:0] R_data
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rdy_q, rdy_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                ren_q, ren_d;
  logic                wen_q, wen_d;
  logic                iord_q, iord_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [DATA_W-1:0]   word_addr_c;
  logic                req_err_c;

  assign word_addr_c = {2'b00, req_addr[31:2]};
  assign req_err_c   = (req_addr[1:0] != 2'b00) |
                       (word_addr_c >= DATA_W'(ADDR_WORDS));

  // Next state, held request fields, and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    iord_d  = iord_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = word_addr_c;
          wdata_d = req_wdata;
          err_d   = req_err_c;
          rdata_d = '0;
          // A fetch flag on a store is meaningless; stores always hit the data region.
          iord_d  = req_fetch & ~req_we;
          if (req_err_c) begin
            state_d = RESP;
          end else if (req_we) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      READ: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          rdata_d = R_data;
          state_d = RESP;
        end
      end
      WRITE: begin
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rdy_d    = (state_d == IDLE);
    rvalid_d = (state_d == RESP);
    ren_d    = (state_d == READ);
    wen_d    = (state_d == WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdy_q    <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      iord_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      iord_q   <= iord_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign req_ready  = rdy_q;
  assign resp_valid = rvalid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign R_Enable   = ren_q;
  assign W_Enable   = wen_q;
  assign IorD       = iord_q;
  assign Addr       = addr_q;
  assign W_data     = wdata_q;

endmodule
